// File: rtl/pixbuf_pkg.sv
// Shared constants for the Mandelbrot pixel-buffer strobe interface and its responder.
// Also holds the wrap-around pointer helper used by both buffer pointers.
package pixbuf_pkg;

    localparam int DEFAULT_DEPTH      = 1024;
    localparam int DEFAULT_DATA_WIDTH = 4;

    // Bit positions of the strobes and data within the core's uio byte
    localparam int UIO_READ_BIT            = 7;
    localparam int UIO_RESET_READ_PTR_BIT  = 6;
    localparam int UIO_WRITE_BIT           = 5;
    localparam int UIO_RESET_WRITE_PTR_BIT = 4;
    localparam int UIO_DATA_MSB            = 3;
    localparam int UIO_DATA_LSB            = 0;

    function automatic int unsigned ptr_advance(input int unsigned ptr, input int unsigned depth);
        if (ptr >= depth - 32'd1) begin
            return 32'd0;
        end else begin
            return ptr + 32'd1;
        end
    endfunction

endpackage

// File: rtl/pixel_buffer_responder_if.sv
// Strobe bus between the Mandelbrot core (master) and the pixel-buffer responder (slave).
interface pixel_buffer_responder_if
    import pixbuf_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic                  write;
    logic                  reset_write_ptr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read;
    logic                  reset_read_ptr;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output write,
        output reset_write_ptr,
        output write_data,
        output read,
        output reset_read_ptr,
        input  read_data
    );

    modport slave (
        input  write,
        input  reset_write_ptr,
        input  write_data,
        input  read,
        input  reset_read_ptr,
        output read_data
    );

endinterface

// File: rtl/strobe_sync_edge.sv
// Multi-flop synchroniser with optional rising-edge detect; SYNC_STAGES=0 passes the input straight through.
module strobe_sync_edge
    import pixbuf_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_EN     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] sync_s;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign sync_s = async_in;
        end else begin : g_chain
            logic [WIDTH-1:0] stage_r [SYNC_STAGES];

            // Shift the raw input through the synchroniser chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        stage_r[i] <= {WIDTH{1'b0}};
                    end
                end else begin
                    stage_r[0] <= async_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign sync_s = stage_r[SYNC_STAGES-1];
        end

        if (EDGE_EN) begin : g_edge
            logic [WIDTH-1:0] prev_r;

            // Remember the previous synchronised level for edge detection
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_r <= {WIDTH{1'b0}};
                end else begin
                    prev_r <= sync_s;
                end
            end

            assign rise = sync_s & ~prev_r;
        end else begin : g_no_edge
            assign rise = {WIDTH{1'b0}};
        end
    endgenerate

    assign level = sync_s;

endmodule

// File: rtl/pixel_buffer_responder.sv
// Memory-side responder for the core's pixel-buffer strobes: auto-incrementing write
// and read pointers over a word buffer, with registered read data and frame/drop status.
module pixel_buffer_responder
    import pixbuf_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pixel_buffer_responder_if.slave bus,
    output logic [ADDR_WIDTH-1:0]  wr_ptr,
    output logic [ADDR_WIDTH-1:0]  rd_ptr,
    output logic                   frame_done,
    output logic                   write_dropped
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [1:0]            strobe_pin_s;
    logic [1:0]            strobe_rise_s;
    logic [1:0]            level_pin_s;
    logic [1:0]            level_sync_s;
    logic [DATA_WIDTH-1:0] wdata_sync_s;
    logic [1:0]            unused_strobe_level_s;
    logic [1:0]            unused_level_rise_s;
    logic [DATA_WIDTH-1:0] unused_data_rise_s;

    logic                  write_rise_s;
    logic                  read_rise_s;
    logic                  rst_wp_s;
    logic                  rst_rp_s;

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic                  frame_done_r;
    logic                  write_dropped_r;
    logic [DATA_WIDTH-1:0] read_data_r;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_nxt_s;
    logic [ADDR_WIDTH-1:0] rd_ptr_nxt_s;
    logic                  frame_done_nxt_s;
    logic                  write_dropped_nxt_s;
    logic                  mem_we_s;

    assign strobe_pin_s = {bus.read, bus.write};
    assign level_pin_s  = {bus.reset_read_ptr, bus.reset_write_ptr};

    strobe_sync_edge #(
        .WIDTH       (2),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_EN     (1'b1)
    ) u_strobe_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (strobe_pin_s),
        .level    (unused_strobe_level_s),
        .rise     (strobe_rise_s)
    );

    strobe_sync_edge #(
        .WIDTH       (2),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_EN     (1'b0)
    ) u_level_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (level_pin_s),
        .level    (level_sync_s),
        .rise     (unused_level_rise_s)
    );

    // Data rides the same number of stages so it stays aligned with the write edge
    strobe_sync_edge #(
        .WIDTH       (DATA_WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_EN     (1'b0)
    ) u_data_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus.write_data),
        .level    (wdata_sync_s),
        .rise     (unused_data_rise_s)
    );

    assign write_rise_s = strobe_rise_s[0];
    assign read_rise_s  = strobe_rise_s[1];
    assign rst_wp_s     = level_sync_s[0];
    assign rst_rp_s     = level_sync_s[1];

    // Write-pointer, frame-wrap and dropped-write decisions
    always_comb begin
        wr_ptr_nxt_s        = wr_ptr_r;
        frame_done_nxt_s    = 1'b0;
        write_dropped_nxt_s = write_dropped_r;
        mem_we_s            = 1'b0;
        if (rst_wp_s) begin
            wr_ptr_nxt_s = {ADDR_WIDTH{1'b0}};
            if (write_rise_s) begin
                write_dropped_nxt_s = 1'b1;
            end else begin
                write_dropped_nxt_s = write_dropped_r;
            end
        end else if (write_rise_s) begin
            mem_we_s         = 1'b1;
            wr_ptr_nxt_s     = ADDR_WIDTH'(ptr_advance(32'(wr_ptr_r), 32'(DEPTH)));
            frame_done_nxt_s = (wr_ptr_r == LAST_ADDR);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
    end

    // Read-pointer decisions; a read edge under the level reset is simply ignored
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r;
        if (rst_rp_s) begin
            rd_ptr_nxt_s = {ADDR_WIDTH{1'b0}};
        end else if (read_rise_s) begin
            rd_ptr_nxt_s = ADDR_WIDTH'(ptr_advance(32'(rd_ptr_r), 32'(DEPTH)));
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Pointer, status and read-data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r        <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r        <= {ADDR_WIDTH{1'b0}};
            frame_done_r    <= 1'b0;
            write_dropped_r <= 1'b0;
            read_data_r     <= {DATA_WIDTH{1'b0}};
        end else begin
            wr_ptr_r        <= wr_ptr_nxt_s;
            rd_ptr_r        <= rd_ptr_nxt_s;
            frame_done_r    <= frame_done_nxt_s;
            write_dropped_r <= write_dropped_nxt_s;
            read_data_r     <= mem_r[rd_ptr_r];
        end
    end

    // Buffer storage survives rst_n so a frame can be re-read after a reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wr_ptr_r] <= wdata_sync_s;
        end
    end

    assign wr_ptr        = wr_ptr_r;
    assign rd_ptr        = rd_ptr_r;
    assign frame_done    = frame_done_r;
    assign write_dropped = write_dropped_r;
    assign bus.read_data = read_data_r;

endmodule

// File: tb/tb_pixel_buffer_responder.sv
// Bench for pixel_buffer_responder: two instances (2 sync stages and bypass) driven from one
// uio byte, checked every cycle against a behavioural buffer model plus literal expectations.
module tb_pixel_buffer_responder;
    import pixbuf_pkg::*;

    localparam int DW = 4;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] uio = 8'h00;

    always #5 clk = ~clk;

    pixel_buffer_responder_if #(.DATA_WIDTH(DW)) bus2 ();
    pixel_buffer_responder_if #(.DATA_WIDTH(DW)) bus0 ();

    assign bus2.write           = uio[UIO_WRITE_BIT];
    assign bus2.reset_write_ptr = uio[UIO_RESET_WRITE_PTR_BIT];
    assign bus2.read            = uio[UIO_READ_BIT];
    assign bus2.reset_read_ptr  = uio[UIO_RESET_READ_PTR_BIT];
    assign bus2.write_data      = uio[UIO_DATA_MSB:UIO_DATA_LSB];
    assign bus0.write           = uio[UIO_WRITE_BIT];
    assign bus0.reset_write_ptr = uio[UIO_RESET_WRITE_PTR_BIT];
    assign bus0.read            = uio[UIO_READ_BIT];
    assign bus0.reset_read_ptr  = uio[UIO_RESET_READ_PTR_BIT];
    assign bus0.write_data      = uio[UIO_DATA_MSB:UIO_DATA_LSB];

    logic [AW-1:0] wr_ptr2, rd_ptr2, wr_ptr0, rd_ptr0;
    logic          fd2, fd0, wd2, wd0;

    pixel_buffer_responder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .wr_ptr(wr_ptr2), .rd_ptr(rd_ptr2), .frame_done(fd2), .write_dropped(wd2)
    );

    pixel_buffer_responder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .SYNC_STAGES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .wr_ptr(wr_ptr0), .rd_ptr(rd_ptr0), .frame_done(fd0), .write_dropped(wd0)
    );

    int n_checks = 0;
    int n_fail = 0;
    int fd_hits2 = 0;
    int fd_hits0 = 0;

    // Behavioural model, index 0 = two sync stages, index 1 = bypass
    int         m_wr [2];
    int         m_rd [2];
    logic [3:0] m_rdata [2];
    bit         m_rvalid [2];
    bit         m_fd [2];
    bit         m_wd [2];
    logic [3:0] m_mem [2][DEPTH];
    bit         m_valid [2][DEPTH];
    logic [7:0] m_hist [2][4];

    function automatic int stages(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic logic [7:0] pk(input bit w, input bit rwp, input bit r, input bit rrp, input logic [3:0] d);
        logic [7:0] v;
        v = 8'h00;
        v[UIO_WRITE_BIT] = w;
        v[UIO_RESET_WRITE_PTR_BIT] = rwp;
        v[UIO_READ_BIT] = r;
        v[UIO_RESET_READ_PTR_BIT] = rrp;
        v[UIO_DATA_MSB:UIO_DATA_LSB] = d;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_wr[i] = 0; m_rd[i] = 0; m_rdata[i] = 4'h0; m_rvalid[i] = 1'b1;
            m_fd[i] = 1'b0; m_wd[i] = 1'b0;
            for (int j = 0; j < 4; j++) m_hist[i][j] = 8'h00;
        end
    endtask

    // One clock edge of the buffer as the core sees it: pins become effective after the sync delay
    task automatic model_edge(input int i);
        logic [7:0] eff, prv;
        logic [3:0] nd;
        bit nv, we, re;
        for (int j = 3; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
        m_hist[i][0] = uio;
        eff = m_hist[i][stages(i)];
        prv = m_hist[i][stages(i) + 1];
        we = eff[UIO_WRITE_BIT] & ~prv[UIO_WRITE_BIT];
        re = eff[UIO_READ_BIT] & ~prv[UIO_READ_BIT];
        nd = m_mem[i][m_rd[i]];
        nv = m_valid[i][m_rd[i]];
        m_fd[i] = 1'b0;
        if (eff[UIO_RESET_WRITE_PTR_BIT]) begin
            m_wr[i] = 0;
            if (we) m_wd[i] = 1'b1;
        end else if (we) begin
            m_mem[i][m_wr[i]] = eff[UIO_DATA_MSB:UIO_DATA_LSB];
            m_valid[i][m_wr[i]] = 1'b1;
            m_fd[i] = (m_wr[i] == DEPTH - 1);
            m_wr[i] = (m_wr[i] + 1) % DEPTH;
        end
        if (eff[UIO_RESET_READ_PTR_BIT]) m_rd[i] = 0;
        else if (re) m_rd[i] = (m_rd[i] + 1) % DEPTH;
        m_rdata[i] = nd;
        m_rvalid[i] = nv;
    endtask

    task automatic compare_all();
        chk("wr_ptr_s2", int'(wr_ptr2), m_wr[0]);
        chk("rd_ptr_s2", int'(rd_ptr2), m_rd[0]);
        chk("frame_done_s2", int'(fd2), int'(m_fd[0]));
        chk("write_dropped_s2", int'(wd2), int'(m_wd[0]));
        if (m_rvalid[0]) chk("read_data_s2", int'(bus2.read_data), int'(m_rdata[0]));
        chk("wr_ptr_s0", int'(wr_ptr0), m_wr[1]);
        chk("rd_ptr_s0", int'(rd_ptr0), m_rd[1]);
        chk("frame_done_s0", int'(fd0), int'(m_fd[1]));
        chk("write_dropped_s0", int'(wd0), int'(m_wd[1]));
        if (m_rvalid[1]) chk("read_data_s0", int'(bus0.read_data), int'(m_rdata[1]));
    endtask

    task automatic step(input logic [7:0] pins);
        uio = pins;
        @(posedge clk);
        if (rst_n) begin
            model_edge(0);
            model_edge(1);
        end
        @(negedge clk);
        compare_all();
        if (fd2) fd_hits2++;
        if (fd0) fd_hits0++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(8'h00);
    endtask

    task automatic wr_pulse(input logic [3:0] d);
        step(pk(1'b1, 1'b0, 1'b0, 1'b0, d));
        step(8'h00);
    endtask

    task automatic rd_pulse();
        step(pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h0));
        step(8'h00);
    endtask

    initial begin
        bit pw, pr, w, r;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < DEPTH; j++) m_valid[i][j] = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        chk("reset_wr_ptr", int'(wr_ptr2), 0);
        chk("reset_rd_ptr", int'(rd_ptr2), 0);
        chk("reset_read_data", int'(bus2.read_data), 0);
        chk("reset_flags", int'({fd2, wd2, fd0, wd0}), 0);

        // Sequential fill and read-back
        step(pk(1'b0, 1'b1, 1'b0, 1'b0, 4'h0));
        idle(4);
        for (int i = 0; i < 8; i++) wr_pulse(4'(i));
        step(pk(1'b0, 1'b0, 1'b0, 1'b1, 4'h0));
        idle(4);
        chk("fill_wr_ptr", int'(wr_ptr2), 8);
        chk("model_fill_wr_ptr", m_wr[0], 8);
        chk("fill_rd_ptr", int'(rd_ptr2), 0);
        chk("fill_read_data0", int'(bus2.read_data), 0);
        for (int i = 1; i < 8; i++) begin
            rd_pulse();
            idle(3);
            chk("seq_read_data", int'(bus2.read_data), i);
        end

        // Frame wrap and overwrite from address 0
        for (int i = 8; i < 15; i++) wr_pulse(4'(i));
        idle(4);
        fd_hits2 = 0;
        fd_hits0 = 0;
        wr_pulse(4'hF);
        idle(5);
        chk("frame_done_pulses_s2", fd_hits2, 1);
        chk("frame_done_pulses_s0", fd_hits0, 1);
        chk("wrap_wr_ptr", int'(wr_ptr2), 0);
        wr_pulse(4'hA);
        step(pk(1'b0, 1'b0, 1'b0, 1'b1, 4'h0));
        idle(4);
        chk("overwrite_read_data", int'(bus2.read_data), 10);
        chk("model_overwrite", int'(m_rdata[0]), 10);

        // Write edge under reset_write_ptr is dropped
        step(pk(1'b1, 1'b1, 1'b0, 1'b0, 4'h3));
        idle(5);
        chk("dropped_s2", int'(wd2), 1);
        chk("dropped_s0", int'(wd0), 1);
        chk("dropped_wr_ptr", int'(wr_ptr2), 0);
        step(pk(1'b0, 1'b0, 1'b0, 1'b1, 4'h0));
        idle(4);
        chk("dropped_mem_unchanged", int'(bus2.read_data), 10);

        // Write-through to the address under the read pointer
        for (int i = 0; i < 3; i++) rd_pulse();
        for (int i = 0; i < 3; i++) wr_pulse(4'hC);
        idle(5);
        chk("wt_rd_ptr", int'(rd_ptr2), 3);
        chk("wt_wr_ptr", int'(wr_ptr2), 3);
        chk("wt_before", int'(bus2.read_data), 3);
        step(pk(1'b1, 1'b0, 1'b0, 1'b0, 4'h5));
        idle(2);
        chk("wt_wr_ptr_after", int'(wr_ptr2), 4);
        chk("wt_stale_one_cycle", int'(bus2.read_data), 3);
        idle(1);
        chk("wt_new_word", int'(bus2.read_data), 5);

        // Action latency from a pin edge
        step(pk(1'b0, 1'b1, 1'b0, 1'b0, 4'h0));
        idle(4);
        step(pk(1'b1, 1'b0, 1'b0, 1'b0, 4'h9));
        chk("lat_s0_n1", int'(wr_ptr0), 1);
        chk("lat_s2_n1", int'(wr_ptr2), 0);
        idle(1);
        chk("lat_s2_n2", int'(wr_ptr2), 0);
        idle(1);
        chk("lat_s2_n3", int'(wr_ptr2), 1);
        idle(3);

        // Randomised traffic, respecting one low cycle between strobe pulses
        pw = 1'b0;
        pr = 1'b0;
        for (int k = 0; k < 400; k++) begin
            w = ($urandom_range(0, 1) == 1) && !pw;
            r = ($urandom_range(0, 2) == 0) && !pr;
            step(pk(w, ($urandom_range(0, 11) == 0), r, ($urandom_range(0, 11) == 0), 4'($urandom_range(0, 15))));
            pw = w;
            pr = r;
        end
        idle(5);

        // Asynchronous reset mid-operation, then re-read the retained words
        step(pk(1'b0, 1'b1, 1'b0, 1'b1, 4'h0));
        idle(4);
        for (int i = 1; i <= 5; i++) wr_pulse(4'(i));
        rd_pulse();
        rd_pulse();
        idle(5);
        chk("pre_reset_wr_ptr", int'(wr_ptr2), 5);
        chk("pre_reset_rd_ptr", int'(rd_ptr2), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ptrs", int'({wr_ptr2, rd_ptr2, wr_ptr0, rd_ptr0}), 0);
        chk("async_rst_flags", int'({fd2, wd2, fd0, wd0}), 0);
        chk("async_rst_rdata", int'({bus2.read_data, bus0.read_data}), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(pk(1'b0, 1'b0, 1'b0, 1'b1, 4'h0));
        idle(4);
        chk("retained_addr0", int'(bus2.read_data), 1);
        rd_pulse();
        idle(3);
        chk("retained_addr1", int'(bus2.read_data), 2);
        chk("retained_addr1_s0", int'(bus0.read_data), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
